// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter (ALU vs load unit) onto the single register-file write port, plus a
// busy scoreboard that stalls decode on RAW/WAW hazards. Optional macro: RF_WB_ROUND_ROBIN_EN.
module regfile_wb_scheduler #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic             issue_uses_rd,
  input  logic [4:0]       issue_rd,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  output logic             issue_stall,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  output logic             mem_ready,
  output logic [4:0]       waddr,
  output logic [XLEN-1:0]  wdata,
  output logic             registers_wen,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic             wen_q, wen_d;

  logic             alu_win, alu_acc, mem_acc, issue_fire;
  logic [4:0]       acc_rd;
  logic [XLEN-1:0]  acc_data;

`ifdef RF_WB_ROUND_ROBIN_EN
  logic last_alu_q, last_alu_d;

  // On contention the ALU wins only if the load unit was granted most recently.
  always_comb alu_win = !mem_valid || !last_alu_q;

  always_comb begin
    last_alu_d = last_alu_q;
    if (alu_acc)      last_alu_d = 1'b1;
    else if (mem_acc) last_alu_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) last_alu_q <= 1'b1;
    else      last_alu_q <= last_alu_d;
  end
`else
  always_comb alu_win = !mem_valid;
`endif

  always_comb begin
    alu_ready   = rst & alu_valid & alu_win;
    mem_ready   = rst & mem_valid & !(alu_valid & alu_win);
    alu_acc     = alu_ready;
    mem_acc     = mem_ready;
    issue_stall = rst & issue_valid &
                  (busy_q[issue_rs1] | busy_q[issue_rs2] | (issue_uses_rd & busy_q[issue_rd]));
    issue_fire  = rst & issue_valid & !issue_stall;
    acc_rd      = alu_acc ? alu_rd   : mem_rd;
    acc_data    = alu_acc ? alu_data : mem_data;
  end

  always_comb begin
    busy_d  = busy_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    if (issue_fire && issue_uses_rd) busy_d[issue_rd] = 1'b1;
    if (alu_acc || mem_acc) begin
      busy_d[acc_rd] = 1'b0;
      waddr_d        = acc_rd;
      wdata_d        = acc_data;
      wen_d          = (acc_rd != 5'd0);
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
    end
  end

  assign busy          = busy_q;
  assign waddr         = waddr_q;
  assign wdata         = wdata_q;
  assign registers_wen = wen_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomised + directed bench: a reference model predicts grants, stalls and the scoreboard;
// expected register-file writes go into a queue that a separate monitor drains.
module tb_regfile_wb_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_uses_rd;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_stall;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [4:0]  alu_rd, mem_rd, waddr;
  logic [31:0] alu_data, mem_data, wdata;
  logic        registers_wen;
  logic [31:0] busy;

  regfile_wb_scheduler dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_uses_rd(issue_uses_rd), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .waddr(waddr), .wdata(wdata), .registers_wen(registers_wen), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];

  // Reference state: set of registers with writes in flight, last write port contents,
  // and which source (0 = ALU, 1 = load) was granted most recently.
  bit          pend[32];
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_wen;
  int          last_src;
  bit          got_alu, got_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (registers_wen === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL wb_unexpected: got write addr %0d data %h, expected none", waddr, wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if (waddr !== e.a || wdata !== e.d) begin
            bad++;
            $display("FAIL wb_data: got addr %0d data %h, expected addr %0d data %h",
                     waddr, wdata, e.a, e.d);
          end
        end
      end
    end
  end

  task automatic step(input bit r, input bit iv, input bit ur, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit av, input logic [4:0] ard, input logic [31:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    logic [31:0] exp_busy;
    bit e_stall, e_ar, e_mr, fire;
    @(negedge clk);
    exp_busy = '0;
    for (int i = 0; i < 32; i++) exp_busy[i] = pend[i];
    chk("busy", busy, exp_busy);
    chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
    chk("wdata", wdata, m_wdata);
    chk("wen", {31'd0, registers_wen}, {31'd0, m_wen});
    rst = r; issue_valid = iv; issue_uses_rd = ur; issue_rd = rd;
    issue_rs1 = rs1; issue_rs2 = rs2;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    e_stall = 0; e_ar = 0; e_mr = 0;
    if (r) begin
      e_stall = iv && (pend[rs1] || pend[rs2] || (ur && pend[rd]));
      if (av && mv) begin
`ifdef RF_WB_ROUND_ROBIN_EN
        if (last_src == 1) e_ar = 1; else e_mr = 1;
`else
        e_mr = 1;
`endif
      end else begin
        e_ar = av;
        e_mr = mv;
      end
    end
    chk("issue_stall", {31'd0, issue_stall}, {31'd0, e_stall});
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, e_ar});
    chk("mem_ready", {31'd0, mem_ready}, {31'd0, e_mr});
    got_alu = e_ar;
    got_mem = e_mr;
    if (!r) begin
      foreach (pend[i]) pend[i] = 0;
      m_waddr = 0; m_wdata = 0; m_wen = 0; last_src = 0;
    end else begin
      fire = iv && !e_stall;
      m_wen = 0;
      if (e_ar || e_mr) begin
        m_waddr = e_ar ? ard : mrd;
        m_wdata = e_ar ? ad : md;
        m_wen   = (m_waddr != 0);
        pend[m_waddr] = 0;
        last_src = e_ar ? 0 : 1;
        if (m_wen) begin
          wr_t w;
          w.a = m_waddr; w.d = m_wdata;
          exp_q.push_back(w);
        end
      end
      if (fire && ur && rd != 0) pend[rd] = 1;
    end
  endtask

  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  bit          a_v, m_v;
  logic [4:0]  a_rd, m_rd;
  logic [31:0] a_d, m_d;

  function automatic logic [4:0] pick_rd(input logic [4:0] avoid);
    int cand[$];
    for (int i = 1; i < 32; i++) if (pend[i] && i != avoid) cand.push_back(i);
    if (cand.size() == 0 || $urandom_range(0, 9) == 0) return 5'd0;
    return 5'(cand[$urandom_range(0, cand.size() - 1)]);
  endfunction

  initial begin
    rst = 0; issue_valid = 0; issue_uses_rd = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0; mem_valid = 0; mem_rd = 0; mem_data = 0;
    foreach (pend[i]) pend[i] = 0;
    m_waddr = 0; m_wdata = 0; m_wen = 0; last_src = 0;
    @(posedge clk);

    // Reset held with all inputs active, then a clean idle cycle.
    step(0, 1, 1, 5, 5, 5, 1, 3, 32'h1111_1111, 1, 4, 32'h2222_2222);
    step(0, 1, 1, 5, 5, 5, 1, 3, 32'h1111_1111, 1, 4, 32'h2222_2222);
    idle(1);
    idle(1);

    // RAW: issue rd5, dependent issue stalls until the ALU writeback lands.
    step(1, 1, 1, 5, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 8, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 8, 5, 0, 1, 5, 32'hDEAD_BEEF, 0, 0, 0);
    step(1, 1, 1, 8, 5, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 8, 32'h0808_0808, 0, 0, 0);
    idle(1);

    // x0: nothing becomes busy, writeback is granted but not written.
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hCAFE_0000);
    idle(1);

    // Contention after reset: load first, then ALU.
    idle(0);
    step(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 3, 32'h0000_0333, 1, 4, 32'h0000_0444);
    step(1, 0, 0, 0, 0, 0, 1, 3, 32'h0000_0333, 0, 0, 0);
    idle(1);
    idle(1);

    // Set and clear of different indices in one cycle.
    step(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 7, 0, 0, 1, 9, 32'h9999_0009, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 7, 32'h7777_0007, 0, 0, 0);
    idle(1);

    // WAW: re-issue of busy rd6 stalls until its writeback is accepted.
    step(1, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 6, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 6, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 6, 1, 2, 0, 0, 0, 1, 6, 32'h6666_0006);
    step(1, 1, 1, 6, 1, 2, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 32'h6666_1006);
    idle(1);

    // Randomised traffic with occasional mid-operation reset.
    a_v = 0; m_v = 0; a_rd = 0; m_rd = 0; a_d = 0; m_d = 0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      r = ($urandom_range(0, 299) != 0);
      if (!a_v && $urandom_range(0, 2) != 0) begin
        a_rd = pick_rd(m_v ? m_rd : 5'd0);
        if (a_rd != 0 || $urandom_range(0, 3) == 0) begin a_v = 1; a_d = $urandom; end
      end
      if (!m_v && $urandom_range(0, 2) != 0) begin
        m_rd = pick_rd(a_v ? a_rd : 5'd0);
        if (m_rd != 0 || $urandom_range(0, 3) == 0) begin m_v = 1; m_d = $urandom; end
      end
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)),
           a_v, a_rd, a_d, m_v, m_rd, m_d);
      if (!r) begin a_v = 0; m_v = 0; end
      if (got_alu) a_v = 0;
      if (got_mem) m_v = 0;
    end
    idle(1);
    idle(1);
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
